pll_reconfig_ctrl: RTL
======================

# pll_reconfig_ctrl

Sequencer for the dynamic-configuration side of the on-chip PLL wrapper. It performs the power-on lock sequence and accepts runtime requests for new feedback/output divider settings (MDSEL, ODSEL0, ODSEL1). For each request it gates the PLL output clocks, holds the PLL in reset while the new selects settle, waits for a stable LOCK with timeout and retry, then ungates. It runs on the free-running board input clock (50 MHz), never on a PLL output.

## Interface
Parameters:
- MDIV_DEFAULT, 17, MDSEL value driven from reset.
- ODIV0_DEFAULT, 5, ODSEL0 value driven from reset.
- ODIV1_DEFAULT, 4, ODSEL1 value driven from reset.
- RST_CYCLES, 16, cycles `pll_reset` is held high per attempt (≥2).
- LOCK_STABLE, 8, consecutive synchronized-high LOCK samples required (≥1).
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK per attempt.
- MAX_RETRY, 3, extra attempts after the first timeout.

Ports:
- clk  in  1  free-running input clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_valid  in  1  new configuration request.
- cfg_ready  out  1  request can be accepted.
- cfg_mdiv  in  7  requested MDSEL value.
- cfg_odiv0  in  7  requested ODSEL0 value.
- cfg_odiv1  in  7  requested ODSEL1 value.
- cfg_bad  out  1  one-cycle pulse: accepted request rejected (a field was 0).
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- pll_reset  out  1  to PLL RESET.
- pll_mdsel  out  7  to MDSEL.
- pll_odsel0  out  7  to ODSEL0.
- pll_odsel1  out  7  to ODSEL1.
- pll_enclk  out  1  to ENCLK0 and ENCLK1; 0 = outputs gated.
- busy  out  1  sequence in progress.
- locked  out  1  PLL locked and outputs enabled.
- err  out  1  sticky: retries exhausted.

## Operation
- Encoding: `pll_*sel` are driven verbatim from the stored config, with no translation.
- Reset values:
  - `pll_reset`=1, `pll_enclk`=0, `cfg_ready`=0, `busy`=1, `locked`=0, `err`=0, `cfg_bad`=0.
  - Selects = *_DEFAULT.
  - State = RESET with the counter cleared. This gives an automatic power-on sequence.
- `pll_lock` passes through a 2-FF synchronizer (`lock_s`). All LOCK decisions use `lock_s`.
- States:
  - IDLE: `cfg_ready`=1, `locked`=1, `pll_enclk`=1, `busy`=0.
  - GATE: `pll_enclk`=0 for 2 cycles, then → RESET.
  - RESET:
    - `pll_reset`=1 for RST_CYCLES.
    - Selects load the pending config on the first cycle.
    - Then → WAIT_LOCK with the timeout and stable counters cleared.
  - WAIT_LOCK:
    - `pll_reset`=0.
    - The stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
    - Stable counter reaches LOCK_STABLE → IDLE and clear the retry count.
    - Otherwise, timeout counter reaches LOCK_TIMEOUT:
      - If retry < MAX_RETRY: retry++ and → RESET, keeping the same config.
      - Else → FAIL.
  - FAIL: `err`=1, `pll_reset`=0, `pll_enclk`=0, `busy`=0, `cfg_ready`=1.
- Handshake:
  - Accept when `cfg_valid`&`cfg_ready` at a rising edge.
  - If any field is 0: `cfg_bad`=1 for the next cycle, the config is unchanged, and the state is unchanged.
  - Otherwise: the fields are captured, `err` is cleared, retry is cleared, and the state → GATE.
- Loss of lock in IDLE:
  - `lock_s`=0 for LOCK_STABLE consecutive cycles → GATE.
  - The current config is reused; this counts as a fresh sequence with retry cleared.
  - `locked` drops on the cycle the state leaves IDLE.
- `cfg_valid` outside IDLE/FAIL is ignored; the requester must hold it.
- Counters saturate and never wrap. The timeout counter needs ≥ clog2(LOCK_TIMEOUT+1) bits.

## Timing
- All outputs are registered.
- Accept at edge T:
  - T+1: GATE; `busy`=1, `cfg_ready`=0, `locked`=0, `pll_enclk`=0.
  - T+3: RESET; `pll_reset`=1 and new selects appear.
  - T+3+RST_CYCLES: `pll_reset`=0.
- Lock path: LOCK rising at edge L (already past RESET) gives `locked`=1, `pll_enclk`=1 and `cfg_ready`=1 at L+2+LOCK_STABLE (±1 for synchronizer phase).
- Simultaneous events: `lock_s` reaching stable on the same edge as timeout → lock wins.
- Asynchronous reset asserted in any state: outputs return to reset values immediately and the power-on sequence restarts with the defaults. The captured config is discarded.

## Test plan
- Power-on: release `rst_n`, model raises LOCK 100 cycles later.
  - Required: `pll_reset` high for 16 cycles.
  - Required: `locked`/`pll_enclk`=1 about 10 cycles after LOCK rises.
  - Required: selects = 17/5/4.
- Reconfig: in IDLE send mdiv=20, odiv0=6, odiv1=3.
  - Required: `pll_enclk`=0 at T+1.
  - Required: selects 20/6/3 and `pll_reset`=1 at T+3.
  - Required: relock, then `busy`=0.
- Timeout: LOCK held low, LOCK_TIMEOUT=200.
  - Required: 4 reset pulses, then FAIL with `err`=1, `cfg_ready`=1, `pll_enclk`=0.
  - Then a valid request clears `err`.
- Bad config: mdiv=0.
  - Required: `cfg_bad` pulse for one cycle, no state change, selects unchanged.
- Lock loss: drop LOCK in IDLE for 8+ cycles.
  - Required: `locked`=0, regate, reset pulse, relock with the same selects.
  - A 3-cycle LOCK glitch causes no action.
- Asynchronous reset mid-WAIT_LOCK during a 20/6/3 sequence.
  - Required: immediate `pll_reset`=1, `pll_enclk`=0, selects 17/5/4.

Source files
------------

// File: rtl/pll_reconfig_if.sv
// Configuration request channel for the PLL reconfiguration sequencer.
interface pll_reconfig_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [6:0] cfg_mdiv;
    logic [6:0] cfg_odiv0;
    logic [6:0] cfg_odiv1;
    logic       cfg_bad;

    // Requester side
    modport master (
        output cfg_valid, cfg_mdiv, cfg_odiv0, cfg_odiv1,
        input  cfg_ready, cfg_bad
    );

    // Sequencer side
    modport slave (
        input  cfg_valid, cfg_mdiv, cfg_odiv0, cfg_odiv1,
        output cfg_ready, cfg_bad
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL lock/reconfiguration sequencer: gates outputs, pulses PLL reset with new
// divider selects, waits for a stable LOCK with timeout/retry, then ungates.
module pll_reconfig_ctrl #(
    parameter int unsigned MDIV_DEFAULT  = 17,
    parameter int unsigned ODIV0_DEFAULT = 5,
    parameter int unsigned ODIV1_DEFAULT = 4,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE   = 8,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_reconfig_if.slave        cfg,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic [6:0]           pll_mdsel,
    output logic [6:0]           pll_odsel0,
    output logic [6:0]           pll_odsel1,
    output logic                 pll_enclk,
    output logic                 busy,
    output logic                 locked,
    output logic                 err
);

    localparam int unsigned SEL_W = 7;
    localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    localparam logic [SEL_W-1:0] MDIV_RST  = SEL_W'(MDIV_DEFAULT);
    localparam logic [SEL_W-1:0] ODIV0_RST = SEL_W'(ODIV0_DEFAULT);
    localparam logic [SEL_W-1:0] ODIV1_RST = SEL_W'(ODIV1_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_RESET,
        ST_WAIT,
        ST_FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [STB_W-1:0]   stab_q, stab_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [1:0]         sync_q, sync_d;
    logic [SEL_W-1:0]   pend_md_q, pend_md_d;
    logic [SEL_W-1:0]   pend_o0_q, pend_o0_d;
    logic [SEL_W-1:0]   pend_o1_q, pend_o1_d;
    logic [SEL_W-1:0]   mdsel_q, mdsel_d;
    logic [SEL_W-1:0]   odsel0_q, odsel0_d;
    logic [SEL_W-1:0]   odsel1_q, odsel1_d;
    logic               pll_reset_q, pll_reset_d;
    logic               pll_enclk_q, pll_enclk_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               cfg_bad_q, cfg_bad_d;
    logic               busy_q, busy_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;

    logic               lock_s;
    logic               accept;
    logic               cfg_zero;
    logic               loss;
    logic               lock_done;
    logic               tmo_done;

    assign lock_s = sync_q[1];

    // Next-state, counters, config capture and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        stab_d    = stab_q;
        retry_d   = retry_q;
        sync_d    = {sync_q[0], pll_lock};
        pend_md_d = pend_md_q;
        pend_o0_d = pend_o0_q;
        pend_o1_d = pend_o1_q;
        mdsel_d   = mdsel_q;
        odsel0_d  = odsel0_q;
        odsel1_d  = odsel1_q;
        err_d     = err_q;
        cfg_bad_d = 1'b0;
        loss      = 1'b0;
        lock_done = 1'b0;
        tmo_done  = 1'b0;

        accept   = cfg.cfg_valid & cfg_ready_q;
        cfg_zero = (cfg.cfg_mdiv == '0) || (cfg.cfg_odiv0 == '0) || (cfg.cfg_odiv1 == '0);

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                // In IDLE the stable counter tracks consecutive low LOCK samples
                if (state_q == ST_IDLE) begin
                    if (!lock_s) begin
                        if (stab_q == STB_LAST) loss = 1'b1;
                        else                    stab_d = stab_q + STB_W'(1);
                    end else begin
                        stab_d = '0;
                    end
                end
                if (accept && cfg_zero) begin
                    cfg_bad_d = 1'b1;
                end else if (accept) begin
                    pend_md_d = cfg.cfg_mdiv;
                    pend_o0_d = cfg.cfg_odiv0;
                    pend_o1_d = cfg.cfg_odiv1;
                    err_d     = 1'b0;
                    retry_d   = '0;
                    cnt_d     = '0;
                    state_d   = ST_GATE;
                end else if (loss) begin
                    retry_d   = '0;
                    cnt_d     = '0;
                    state_d   = ST_GATE;
                end
            end
            ST_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RESET;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    stab_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (lock_s) begin
                    if (stab_q == STB_LAST) lock_done = 1'b1;
                    else                    stab_d = stab_q + STB_W'(1);
                end else begin
                    stab_d = '0;
                end
                if (tmo_q == TMO_LAST) tmo_done = 1'b1;
                else                   tmo_d = tmo_q + TMO_W'(1);
                // Lock takes priority over a coincident timeout
                if (lock_done) begin
                    stab_d  = '0;
                    retry_d = '0;
                    state_d = ST_IDLE;
                end else if (tmo_done) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        cnt_d   = '0;
                        state_d = ST_RESET;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Selects take the pending config as reset is (re)asserted
        if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
            mdsel_d  = pend_md_q;
            odsel0_d = pend_o0_q;
            odsel1_d = pend_o1_q;
        end

        pll_reset_d = 1'b0;
        pll_enclk_d = 1'b0;
        cfg_ready_d = 1'b0;
        busy_d      = 1'b1;
        locked_d    = 1'b0;
        case (state_d)
            ST_IDLE: begin
                pll_enclk_d = 1'b1;
                cfg_ready_d = 1'b1;
                busy_d      = 1'b0;
                locked_d    = 1'b1;
            end
            ST_RESET: pll_reset_d = 1'b1;
            ST_FAIL: begin
                cfg_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: ;
        endcase
    end

    // State and output registers; reset restarts the power-on sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            tmo_q       <= '0;
            stab_q      <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pend_md_q   <= MDIV_RST;
            pend_o0_q   <= ODIV0_RST;
            pend_o1_q   <= ODIV1_RST;
            mdsel_q     <= MDIV_RST;
            odsel0_q    <= ODIV0_RST;
            odsel1_q    <= ODIV1_RST;
            pll_reset_q <= 1'b1;
            pll_enclk_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_bad_q   <= 1'b0;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            stab_q      <= stab_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            pend_md_q   <= pend_md_d;
            pend_o0_q   <= pend_o0_d;
            pend_o1_q   <= pend_o1_d;
            mdsel_q     <= mdsel_d;
            odsel0_q    <= odsel0_d;
            odsel1_q    <= odsel1_d;
            pll_reset_q <= pll_reset_d;
            pll_enclk_q <= pll_enclk_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_bad_q   <= cfg_bad_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_bad   = cfg_bad_q;
    assign pll_reset     = pll_reset_q;
    assign pll_mdsel     = mdsel_q;
    assign pll_odsel0    = odsel0_q;
    assign pll_odsel1    = odsel1_q;
    assign pll_enclk     = pll_enclk_q;
    assign busy          = busy_q;
    assign locked        = locked_q;
    assign err           = err_q;

endmodule
